// File: rtl/pacote_rv32i.sv
// Shared RV32I definitions for the load/store path: funct3 codes, FSM encoding
// and the command-legality check.
package pacote_rv32i;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LER       = 2'd1,
        ESCREVER  = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    // Misaligned halfword/word, reserved funct3, or an unsigned width on a store.
    function automatic logic comando_invalido(input logic       escrita,
                                              input logic [2:0] funct3,
                                              input logic [1:0] deslocamento);
        logic invalido;
        case (funct3)
            F3_B:    invalido = 1'b0;
            F3_H:    invalido = deslocamento[0];
            F3_W:    invalido = (deslocamento != 2'b00);
            F3_BU:   invalido = escrita;
            F3_HU:   invalido = escrita | deslocamento[0];
            default: invalido = 1'b1;
        endcase
        return invalido;
    endfunction

endpackage

// File: rtl/alinhador_dados.sv
// Combinational lane handling: extracts and extends the addressed byte/halfword
// of a loaded word, and merges store data into the old word for partial stores.
module alinhador_dados
    import pacote_rv32i::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  deslocamento,
    input  logic [31:0] palavra_lida,
    input  logic [31:0] palavra_antiga,
    input  logic [31:0] dado_store,
    output logic [31:0] dado_alinhado,
    output logic [31:0] palavra_mesclada
);

    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_sel = palavra_lida[7:0];
        case (deslocamento)
            2'd1:    byte_sel = palavra_lida[15:8];
            2'd2:    byte_sel = palavra_lida[23:16];
            2'd3:    byte_sel = palavra_lida[31:24];
            default: byte_sel = palavra_lida[7:0];
        endcase
        meia_sel = deslocamento[1] ? palavra_lida[31:16] : palavra_lida[15:0];

        dado_alinhado = palavra_lida;
        case (funct3)
            F3_B:    dado_alinhado = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    dado_alinhado = {{16{meia_sel[15]}}, meia_sel};
            F3_BU:   dado_alinhado = {24'h0, byte_sel};
            F3_HU:   dado_alinhado = {16'h0, meia_sel};
            default: dado_alinhado = palavra_lida;
        endcase
    end

    always_comb begin
        palavra_mesclada = dado_store;
        case (funct3)
            F3_B: begin
                palavra_mesclada = palavra_antiga;
                case (deslocamento)
                    2'd0: palavra_mesclada[7:0]   = dado_store[7:0];
                    2'd1: palavra_mesclada[15:8]  = dado_store[7:0];
                    2'd2: palavra_mesclada[23:16] = dado_store[7:0];
                    2'd3: palavra_mesclada[31:24] = dado_store[7:0];
                    default: palavra_mesclada = palavra_antiga;
                endcase
            end
            F3_H: begin
                palavra_mesclada = palavra_antiga;
                if (deslocamento[1]) palavra_mesclada[31:16] = dado_store[15:0];
                else                 palavra_mesclada[15:0]  = dado_store[15:0];
            end
            default: palavra_mesclada = dado_store;
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// RV32I load/store unit: sequences word-only accesses to mem_dados, doing
// read-modify-write for byte/halfword stores and extension for loads.
module unidade_load_store
    import pacote_rv32i::*;
(
    input  logic        sinal_clk,
    input  logic        sinal_rst_n,
    input  logic        requisicao,
    input  logic        escrita_ls,
    input  logic [2:0]  funct3,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_store,
    output logic        pronto,
    output logic        erro_alinhamento,
    output logic        ocupado,
    output logic [31:0] dado_load,
    output logic        mem_habilitar_escrita,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado_escrita,
    input  logic [31:0] mem_dado_leitura
);

    estado_t     estado, proximo;
    logic        escrita_r;
    logic        erro_r;
    logic [2:0]  funct3_r;
    logic [31:0] endereco_r;
    logic [31:0] dado_store_r;
    logic [31:0] palavra_antiga_r;
    logic [31:0] dado_alinhado;
    logic [31:0] palavra_mesclada;
    logic        invalido;
    logic        aceitar;

    assign invalido = comando_invalido(escrita_ls, funct3, endereco[1:0]);
    assign aceitar  = (estado == OCIOSO) && requisicao;

    alinhador_dados u_alinhador (
        .funct3           (funct3_r),
        .deslocamento     (endereco_r[1:0]),
        .palavra_lida     (mem_dado_leitura),
        .palavra_antiga   (palavra_antiga_r),
        .dado_store       (dado_store_r),
        .dado_alinhado    (dado_alinhado),
        .palavra_mesclada (palavra_mesclada)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sinal_clk or negedge sinal_rst_n) begin
        if (!sinal_rst_n) estado <= OCIOSO;
        else              estado <= proximo;
    end

    always_comb begin
        proximo               = estado;
        pronto                = 1'b0;
        erro_alinhamento      = 1'b0;
        ocupado               = 1'b1;
        mem_habilitar_escrita = 1'b0;
        mem_endereco          = 32'h0;
        mem_dado_escrita      = 32'h0;
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (requisicao) begin
                    if (invalido)                proximo = CONCLUIDO;
                    else if (!escrita_ls)        proximo = LER;
                    else if (funct3 == F3_W)     proximo = ESCREVER;
                    else                         proximo = LER;
                end
            end
            LER: begin
                mem_endereco = {endereco_r[31:2], 2'b00};
                proximo      = escrita_r ? ESCREVER : CONCLUIDO;
            end
            ESCREVER: begin
                mem_habilitar_escrita = 1'b1;
                mem_endereco          = {endereco_r[31:2], 2'b00};
                mem_dado_escrita      = palavra_mesclada;
                proximo               = CONCLUIDO;
            end
            CONCLUIDO: begin
                pronto           = 1'b1;
                erro_alinhamento = erro_r;
                proximo          = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge sinal_clk or negedge sinal_rst_n) begin
        if (!sinal_rst_n) begin
            escrita_r        <= 1'b0;
            erro_r           <= 1'b0;
            funct3_r         <= 3'b000;
            endereco_r       <= 32'h0;
            dado_store_r     <= 32'h0;
            palavra_antiga_r <= 32'h0;
            dado_load        <= 32'h0;
        end else begin
            if (aceitar) begin
                escrita_r    <= escrita_ls;
                erro_r       <= invalido;
                funct3_r     <= funct3;
                endereco_r   <= endereco;
                dado_store_r <= dado_store;
            end
            // LER serves both loads and the read half of a partial store.
            if (estado == LER) begin
                if (escrita_r) palavra_antiga_r <= mem_dado_leitura;
                else           dado_load        <= dado_alinhado;
            end
        end
    end

endmodule

// File: tb/tb_unidade_load_store.sv
// Scoreboard bench for unidade_load_store with a word-wide memory model.
module tb_unidade_load_store;

    logic        sinal_clk = 1'b0;
    logic        sinal_rst_n = 1'b0;
    logic        requisicao = 1'b0;
    logic        escrita_ls = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] endereco = 32'h0;
    logic [31:0] dado_store = 32'h0;
    logic        pronto;
    logic        erro_alinhamento;
    logic        ocupado;
    logic [31:0] dado_load;
    logic        mem_habilitar_escrita;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado_escrita;
    logic [31:0] mem_dado_leitura;

    logic [31:0] mem [0:63] = '{16: 32'h8899AABB, 18: 32'h11223344, default: 32'h0};

    typedef struct {
        logic        erro;
        logic [31:0] dado;
        int          ciclo;
        int          escritas;
        int          aceite;
    } esperado_t;

    esperado_t sb[$];
    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int escritas_vistas = 0;

    unidade_load_store dut (
        .sinal_clk             (sinal_clk),
        .sinal_rst_n           (sinal_rst_n),
        .requisicao            (requisicao),
        .escrita_ls            (escrita_ls),
        .funct3                (funct3),
        .endereco              (endereco),
        .dado_store            (dado_store),
        .pronto                (pronto),
        .erro_alinhamento      (erro_alinhamento),
        .ocupado               (ocupado),
        .dado_load             (dado_load),
        .mem_habilitar_escrita (mem_habilitar_escrita),
        .mem_endereco          (mem_endereco),
        .mem_dado_escrita      (mem_dado_escrita),
        .mem_dado_leitura      (mem_dado_leitura)
    );

    always #5 sinal_clk = ~sinal_clk;

    assign mem_dado_leitura = mem[mem_endereco[7:2]];

    always @(posedge sinal_clk) begin
        edge_cnt = edge_cnt + 1;
        if (mem_habilitar_escrita) mem[mem_endereco[7:2]] <= mem_dado_escrita;
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    // Monitor: counts write strobes and scores each completion pulse.
    always @(negedge sinal_clk or negedge sinal_rst_n) begin
        if (!sinal_rst_n) begin
            escritas_vistas = 0;
            sb.delete();
        end else begin
            if (mem_habilitar_escrita) escritas_vistas++;
            if (pronto) begin
                if (sb.size() == 0) begin
                    check("pronto_inesperado", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = sb.pop_front();
                    check("erro_alinhamento", {31'h0, erro_alinhamento}, {31'h0, e.erro});
                    check("ciclo_pronto", edge_cnt - e.aceite + 1, e.ciclo);
                    check("escritas", escritas_vistas, e.escritas);
                    check("dado_load", dado_load, e.dado);
                end
                escritas_vistas = 0;
            end
        end
    end

    task automatic emitir(input logic esc, input logic [2:0] f3, input logic [31:0] ender,
                          input logic [31:0] dado, input logic exp_erro, input logic [31:0] exp_dado,
                          input int exp_ciclo, input int exp_escritas, input bit manter);
        int espera = 0;
        @(negedge sinal_clk);
        while (ocupado && espera < 20) begin
            @(negedge sinal_clk);
            espera++;
        end
        if (espera >= 20) check("espera_ocioso", 32'd1, 32'd0);
        escrita_ls = esc;
        funct3     = f3;
        endereco   = ender;
        dado_store = dado;
        requisicao = 1'b1;
        @(posedge sinal_clk);
        #1;
        sb.push_back('{erro: exp_erro, dado: exp_dado, ciclo: exp_ciclo, escritas: exp_escritas, aceite: edge_cnt});
        check("ocupado_apos_aceite", {31'h0, ocupado}, 32'd1);
        if (!manter) requisicao = 1'b0;
    endtask

    task automatic aguardar_fila();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge sinal_clk);
            n++;
        end
        if (sb.size() != 0) check("fila_pendente", sb.size(), 32'd0);
        @(negedge sinal_clk);
    endtask

    task automatic checar_saidas_zeradas(input string onde);
        check({onde, "_pronto"}, {31'h0, pronto}, 32'd0);
        check({onde, "_erro"}, {31'h0, erro_alinhamento}, 32'd0);
        check({onde, "_ocupado"}, {31'h0, ocupado}, 32'd0);
        check({onde, "_we"}, {31'h0, mem_habilitar_escrita}, 32'd0);
        check({onde, "_mem_endereco"}, mem_endereco, 32'h0);
        check({onde, "_mem_dado_escrita"}, mem_dado_escrita, 32'h0);
        check({onde, "_dado_load"}, dado_load, 32'h0);
    endtask

    initial begin
        #12;
        checar_saidas_zeradas("reset");
        @(negedge sinal_clk);
        sinal_rst_n = 1'b1;

        // Loads from preloaded word 0x8899AABB at 0x40.
        emitir(1'b0, 3'b000, 32'h41, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0, 1'b0);
        emitir(1'b0, 3'b101, 32'h42, 32'h0, 1'b0, 32'h00008899, 2, 0, 1'b0);
        emitir(1'b0, 3'b001, 32'h40, 32'h0, 1'b0, 32'hFFFFAABB, 2, 0, 1'b0);

        // Byte store into lane 3 via read-modify-write.
        emitir(1'b1, 3'b000, 32'h43, 32'h12345677, 1'b0, 32'hFFFFAABB, 3, 1, 1'b0);
        aguardar_fila();
        check("mem_0x40_apos_sb", mem[16], 32'h7799AABB);

        // Rejected commands: misaligned SH/LW, reserved funct3, unsigned store.
        emitir(1'b1, 3'b001, 32'h41, 32'h0, 1'b1, 32'hFFFFAABB, 1, 0, 1'b0);
        emitir(1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 32'hFFFFAABB, 1, 0, 1'b0);
        emitir(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'hFFFFAABB, 1, 0, 1'b0);
        emitir(1'b1, 3'b100, 32'h40, 32'h55, 1'b1, 32'hFFFFAABB, 1, 0, 1'b0);
        aguardar_fila();
        check("mem_0x40_apos_erros", mem[16], 32'h7799AABB);

        emitir(1'b0, 3'b100, 32'h40, 32'h0, 1'b0, 32'h000000BB, 2, 0, 1'b0);
        emitir(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h7799AABB, 2, 0, 1'b0);

        // SW with requisicao held, next command LW expected three edges later.
        emitir(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 1'b0, 32'h7799AABB, 2, 1, 1'b1);
        begin
            int aceite_sw;
            aceite_sw = edge_cnt;
            repeat (2) @(posedge sinal_clk);
            #1;
            escrita_ls = 1'b0;
            funct3     = 3'b010;
            endereco   = 32'h44;
            dado_store = 32'h0;
            @(posedge sinal_clk);
            #1;
            sb.push_back('{erro: 1'b0, dado: 32'hDEADBEEF, ciclo: 2, escritas: 0, aceite: aceite_sw + 3});
            requisicao = 1'b0;
        end
        aguardar_fila();
        check("mem_0x44_apos_sw", mem[17], 32'hDEADBEEF);

        // Reset pulse during ESCREVER of an SB aborts the write.
        emitir(1'b1, 3'b000, 32'h48, 32'h000000AB, 1'b0, 32'hDEADBEEF, 3, 1, 1'b0);
        @(posedge sinal_clk);
        @(negedge sinal_clk);
        check("we_em_escrever", {31'h0, mem_habilitar_escrita}, 32'd1);
        #2 sinal_rst_n = 1'b0;
        #1;
        checar_saidas_zeradas("abort");
        #1 sinal_rst_n = 1'b1;
        @(posedge sinal_clk);
        #1;
        check("mem_0x48_apos_abort", mem[18], 32'h11223344);

        emitir(1'b0, 3'b000, 32'h4B, 32'h0, 1'b0, 32'h00000011, 2, 0, 1'b0);
        emitir(1'b1, 3'b001, 32'h4A, 32'h0000CAFE, 1'b0, 32'h00000011, 3, 1, 1'b0);
        aguardar_fila();
        check("mem_0x48_apos_sh", mem[18], 32'hCAFE3344);

        repeat (3) @(negedge sinal_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
